mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Round-robin scheduler sharing one pipelined 8x8 multiplier (P8x8) among NREQ requesters.
//  Accepts operand pairs over valid/ready, drives the multiplier operands and tags each
//  issue with the requester ID. Returns each product with its ID after the pipeline latency.
//  Sits between the requesting DSP lanes and the single P8x8 instance.
// PARAMETERS
//  IN_WORD_SIZE   8   operand width (xin/yin)
//  OUT_WORD_SIZE  16  product width (pout)
//  NREQ           4   number of requesters, 2..8
//  IDW            2   requester-ID width, clog2(NREQ)
//  MUL_LAT        2   P8x8 latency in edges, from mul_xin/mul_yin update to valid mul_pout, >=1
// PORTS
//  clk        in   1                   system clock, rising edge
//  reset      in   1                   asynchronous, active-high
//  en         in   1                   1 = issue allowed; 0 = drain, then idle
//  req_valid  in   NREQ                request pending, one bit per requester
//  req_ready  out  NREQ                one-hot grant; request accepted on edge with valid&ready
//  req_x      in   NREQ*IN_WORD_SIZE   packed x operands; requester i at [i*IN+:IN]
//  req_y      in   NREQ*IN_WORD_SIZE   packed y operands
//  mul_xin    out  IN_WORD_SIZE        to P8x8 xin, registered
//  mul_yin    out  IN_WORD_SIZE        to P8x8 yin, registered
//  mul_pout   in   OUT_WORD_SIZE       from P8x8 pout
//  res_valid  out  1                   product valid this cycle (single-cycle pulse, no backpressure)
//  res_id     out  IDW                 requester that owns res_pout
//  res_pout   out  OUT_WORD_SIZE       product, = mul_pout when res_valid
//  idle       out  1                   FSM in IDLE and no issue in flight
// BEHAVIOUR
//  Reset values: req_ready=0, mul_xin=0, mul_yin=0, res_valid=0, res_id=0, idle=1.
//  Reset state: FSM=IDLE, rr_ptr=0, tag pipeline cleared.
//  Reset mid-operation: all in-flight tags are discarded; no res_valid is produced for them.
//  FSM (registered):
//   IDLE : en=1 -> RUN.
//   RUN  : en=0 -> DRAIN if any tag is in flight, else IDLE.
//   DRAIN: no grants; all tag stages empty -> IDLE (or RUN if en=1 again).
//  Grant (combinational, RUN only):
//   - Search req_valid from rr_ptr upward, modulo NREQ; first set bit wins.
//   - req_ready = onehot(winner); all zero if no request or state!=RUN.
//   - req_ready never depends on res path (no backpressure).
//  Accept edge E (winner g):
//   - mul_xin<=req_x[g], mul_yin<=req_y[g].
//   - Tag stage0 <= {1,g}; rr_ptr <= (g+1) mod NREQ.
//   - No accept: mul_xin/mul_yin hold, stage0 valid<=0, rr_ptr holds.
//  Tags shift one stage per edge. res_valid/res_id = stage MUL_LAT-1 output, so res_valid is
//   high in the cycle after edge E+MUL_LAT-1 (MUL_LAT cycles after accept). res_pout = mul_pout.
//  Throughput: one accept per cycle sustained; back-to-back results carry correct distinct IDs.
//  Fairness: under full load each requester is granted exactly once per NREQ cycles.
//  Widths: product unsigned, OUT_WORD_SIZE=2*IN_WORD_SIZE; no truncation in this block.
//  Simultaneous: en falling on an accept edge still accepts that request (grant was already
//   combinational in RUN); it drains normally.
//  idle = (state==IDLE) & no tag valid.
// STRUCTURE
//  Shared package mul_share_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2),
//   default IN/OUT word sizes, clog2 helper function.
//  One sub-module: rr_arbiter (NREQ-wide req vector + ptr -> one-hot grant + encoded id).
//  Tag pipeline, operand registers and FSM stay in the top.
//  P8x8 is instantiated outside this block; the bench wires it to mul_xin/mul_yin/mul_pout.
// TESTING (bench: this block + real P8x8, period 100 ns, NREQ=4, MUL_LAT per P8x8)
//  1 Reset: assert reset mid-stream with 2 tags in flight -> outputs at reset values
//    immediately; no res_valid after release; idle=1.
//  2 Single: en=1, only req0 valid x=50,y=100 -> req_ready=4'b0001 for one cycle;
//    MUL_LAT cycles later res_valid=1, res_id=0, res_pout=5000.
//  3 Full-load RR: all four valid, x=30/11/19/17, y=40/20/18/77 -> grants 0,1,2,3,0...;
//    results 1200(id0), 220(id1), 342(id2), 1309(id3), back-to-back.
//  4 Pointer wrap: rr_ptr=3, req0 and req3 valid -> req3 granted first, then req0; ptr wraps to 0.
//  5 Drain: en=0 on the edge req2 (x=99,y=45) is accepted -> accepted; no further grants;
//    res 4455 id2 appears; FSM enters IDLE, idle=1 in the following cycle.
//  6 Extremes: x=255,y=255 -> res_pout=65025; x=0,y=53 -> 0; IDs still match issue order.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing scheduler.
//  - state_t     : scheduler FSM encoding (IDLE / RUN / DRAIN)
//  - DEF_*       : default operand/product widths of the shared P8x8
//  - clog2()     : ceiling log2, used to size requester IDs
package mul_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_IN_WORD_SIZE  = 8;
  localparam int DEF_OUT_WORD_SIZE = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_rr.sv
// Round-robin arbiter: scans req upward from ptr (modulo NREQ), first set
// bit wins.
//  req   in  NREQ  request vector (already gated by the caller)
//  ptr   in  IDW   highest-priority requester this cycle
//  grant out NREQ  one-hot winner, all zero when nothing requests
//  id    out IDW   encoded winner (0 when found=0)
//  found out 1     some requester won
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            found
);

  int idx;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      // Rotate without a modulo operator so NREQ need not be a power of two.
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ lanes.
// Handshake: a request is accepted on the rising edge where
// req_valid[i] & req_ready[i]; req_ready is a combinational one-hot grant
// that only depends on state, rr_ptr and req_valid (no result backpressure).
//  clk, reset        clock / async active-high reset
//  en                1 = issue allowed, 0 = drain in-flight work then idle
//  req_valid/ready   per-requester handshake
//  req_x, req_y      packed operands, requester i at [i*IN_WORD_SIZE +: IN_WORD_SIZE]
//  mul_xin, mul_yin  registered operands to the multiplier
//  mul_pout          product from the multiplier
//  res_valid/id/pout result pulse with owning requester ID
//  idle              FSM idle and nothing in flight
//  fsm_state         current scheduler state (observability)
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int IN_WORD_SIZE  = DEF_IN_WORD_SIZE,
  parameter int OUT_WORD_SIZE = DEF_OUT_WORD_SIZE,
  parameter int NREQ          = 4,
  parameter int IDW           = clog2(NREQ),
  parameter int MUL_LAT       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*IN_WORD_SIZE-1:0] req_x,
  input  logic [NREQ*IN_WORD_SIZE-1:0] req_y,
  output logic [IN_WORD_SIZE-1:0]      mul_xin,
  output logic [IN_WORD_SIZE-1:0]      mul_yin,
  input  logic [OUT_WORD_SIZE-1:0]     mul_pout,
  output logic                         res_valid,
  output logic [IDW-1:0]               res_id,
  output logic [OUT_WORD_SIZE-1:0]     res_pout,
  output logic                         idle,
  output state_t                       fsm_state
);

  state_t              state, state_nxt;
  logic [IDW-1:0]      rr_ptr;
  logic [NREQ-1:0]     req_gated;
  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      win_id;
  logic                accept;
  logic [MUL_LAT-1:0]  tag_v;
  logic [IDW-1:0]      tag_id [MUL_LAT];
  logic                any_tag;

  // Grants exist only in RUN; gating the request vector keeps the arbiter simple.
  assign req_gated = (state == ST_RUN) ? req_valid : '0;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_gated),
    .ptr   (rr_ptr),
    .grant (grant),
    .id    (win_id),
    .found (accept)
  );

  assign req_ready = grant;
  assign any_tag   = |tag_v;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_RUN;
      // An accept on this same edge is in flight too, so it forces DRAIN.
      ST_RUN:   if (!en) state_nxt = (any_tag || accept) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (!any_tag) state_nxt = en ? ST_RUN : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      mul_xin <= '0;
      mul_yin <= '0;
      tag_v   <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
    end else begin
      state     <= state_nxt;
      tag_v[0]  <= accept;
      tag_id[0] <= win_id;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      if (accept) begin
        mul_xin <= req_x[int'(win_id)*IN_WORD_SIZE +: IN_WORD_SIZE];
        mul_yin <= req_y[int'(win_id)*IN_WORD_SIZE +: IN_WORD_SIZE];
        rr_ptr  <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
      end
    end
  end

  assign res_valid = tag_v[MUL_LAT-1];
  assign res_id    = tag_id[MUL_LAT-1];
  assign res_pout  = mul_pout;
  assign idle      = (state == ST_IDLE) && !any_tag;
  assign fsm_state = state;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural P8x8 (latency 2:
// operands registered in the DUT, product registered once more here).
module tb_mul_share_arbiter;
  import mul_share_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 16;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_x = '0;
  logic [NREQ*8-1:0] req_y = '0;
  logic [7:0]        mul_xin, mul_yin;
  logic [15:0]       mul_pout = '0;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [15:0]       res_pout;
  logic              idle;
  state_t            fsm_state;

  always #50 clk = ~clk;

  mul_share_arbiter #(
    .IN_WORD_SIZE(8), .OUT_WORD_SIZE(16), .NREQ(NREQ), .IDW(IDW), .MUL_LAT(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_xin(mul_xin), .mul_yin(mul_yin), .mul_pout(mul_pout),
    .res_valid(res_valid), .res_id(res_id), .res_pout(res_pout),
    .idle(idle), .fsm_state(fsm_state)
  );

  // P8x8 model: one product register after the DUT's operand registers.
  always @(posedge clk) mul_pout <= 16'(mul_xin) * 16'(mul_yin);

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_res(input int id, input int p);
    exp_q.push_back({IDW'(id), 16'(p)});
  endtask

  task automatic chk_res(input string tag);
    logic [W-1:0] e;
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_id"}, 32'(res_id), 32'(e[W-1:16]));
      chk({tag, "_pout"}, 32'(res_pout), 32'(e[15:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int x, input int y);
    req_x[i*8 +: 8] = 8'(x);
    req_y[i*8 +: 8] = 8'(y);
  endtask

  logic [7:0] fx [4];
  logic [7:0] fy [4];
  int         fp [4];
  int         wait_cnt;

  initial begin
    // ---- reset values ----
    #10;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_xin", 32'(mul_xin), 32'd0);
    chk("rst_yin", 32'(mul_yin), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // ---- single request: req0 50*100 ----
    en = 1'b1;
    set_op(0, 50, 100);
    req_valid = 4'b0001;
    #1 chk("single_ready_idle", 32'(req_ready), 32'd0);
    step();
    chk("single_state_run", 32'(fsm_state), 32'(ST_RUN));
    chk("single_ready", 32'(req_ready), 32'b0001);
    push_res(0, 5000);
    step();
    req_valid = 4'b0000;
    #1 chk("single_ready_off", 32'(req_ready), 32'd0);
    chk("single_xin", 32'(mul_xin), 32'd50);
    chk("single_yin", 32'(mul_yin), 32'd100);
    chk("single_early", 32'(res_valid), 32'd0);
    step();
    chk_res("single_res");
    step();
    chk("single_pulse_end", 32'(res_valid), 32'd0);

    // ---- reset mid-stream with two tags in flight (rr_ptr=1 now) ----
    set_op(0, 3, 4);
    set_op(1, 5, 6);
    req_valid = 4'b0011;
    #1 chk("midrst_grant1", 32'(req_ready), 32'b0010);
    step();
    chk("midrst_grant0", 32'(req_ready), 32'b0001);
    step();
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_xin", 32'(mul_xin), 32'd0);
    chk("midrst_yin", 32'(mul_yin), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_res_id", 32'(res_id), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    req_valid = '0;
    en = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midrst_no_res", 32'(res_valid), 32'd0);
      chk("midrst_idle_after", 32'(idle), 32'd1);
    end

    // ---- full-load round robin from rr_ptr=0 ----
    fx = '{8'd30, 8'd11, 8'd19, 8'd17};
    fy = '{8'd40, 8'd20, 8'd18, 8'd77};
    fp = '{1200, 220, 342, 1309};
    for (int i = 0; i < 4; i++) set_op(i, int'(fx[i]), int'(fy[i]));
    en = 1'b1;
    req_valid = 4'b1111;
    step();
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      push_res(k % 4, fp[k % 4]);
      if (k >= 2) chk_res("rr_res");
      else chk("rr_res_early", 32'(res_valid), 32'd0);
      step();
    end
    req_valid = '0;
    chk_res("rr_res_tail6");
    step();
    chk_res("rr_res_tail7");
    step();
    chk("rr_done", 32'(res_valid), 32'd0);

    // ---- pointer wrap: move ptr to 3, then req0+req3 ----
    set_op(2, 7, 9);
    req_valid = 4'b0100;
    #1 chk("wrap_grant2", 32'(req_ready), 32'b0100);
    push_res(2, 63);
    step();
    set_op(3, 12, 13);
    set_op(0, 200, 3);
    req_valid = 4'b1001;
    #1 chk("wrap_grant3", 32'(req_ready), 32'b1000);
    chk("wrap_res_early", 32'(res_valid), 32'd0);
    push_res(3, 156);
    step();
    chk_res("wrap_res2");
    req_valid = 4'b0001;
    #1 chk("wrap_grant0", 32'(req_ready), 32'b0001);
    push_res(0, 600);
    step();
    req_valid = '0;
    chk_res("wrap_res3");
    step();
    chk_res("wrap_res0");
    step();
    chk("wrap_done", 32'(res_valid), 32'd0);

    // ---- drain: en falls on the edge req2 is accepted (ptr=1) ----
    set_op(2, 99, 45);
    req_valid = 4'b0100;
    en = 1'b0;
    #1 chk("drain_grant2", 32'(req_ready), 32'b0100);
    push_res(2, 4455);
    step();
    chk("drain_no_grant", 32'(req_ready), 32'd0);
    chk("drain_state", 32'(fsm_state), 32'(ST_DRAIN));
    chk("drain_busy", 32'(idle), 32'd0);
    step();
    chk_res("drain_res");
    chk("drain_no_grant2", 32'(req_ready), 32'd0);
    step();
    chk("drain_res_end", 32'(res_valid), 32'd0);
    step();
    chk("drain_state_idle", 32'(fsm_state), 32'(ST_IDLE));
    chk("drain_idle", 32'(idle), 32'd1);
    req_valid = '0;

    // ---- extremes (ptr=3, so req0 wins before req1) ----
    en = 1'b1;
    step();
    set_op(0, 255, 255);
    set_op(1, 0, 53);
    req_valid = 4'b0011;
    #1 chk("ext_grant0", 32'(req_ready), 32'b0001);
    push_res(0, 65025);
    step();
    req_valid = 4'b0010;
    #1 chk("ext_grant1", 32'(req_ready), 32'b0010);
    push_res(1, 0);
    step();
    req_valid = '0;
    chk_res("ext_res_max");
    step();
    chk_res("ext_res_zero");
    en = 1'b0;
    wait_cnt = 0;
    while (!idle && wait_cnt < 10) begin
      step();
      wait_cnt++;
    end
    chk("ext_final_idle", 32'(idle), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #1000000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

endmodule
